// File: rtl/core_launcher.sv
// core_launcher: preloads instruction and data memories through a valid/ready load port,
// then on go holds the core in reset for RST_CYCLES cycles, releases it and counts run
// cycles until the core reports done or the MAX_CYCLES limit expires.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   ld_valid_i/ld_ready_o load handshake; ld_sel_i picks imem (0) or dmem (1)
//   ld_data_i             9-bit instruction word or byte in [7:0]
//   go_i, clear_i         single-cycle start / return-to-idle requests
//   im_we_o/addr/wdata    instruction memory write port (same-cycle as the transfer)
//   dm_we_o/addr/wdata    data memory write port (same-cycle as the transfer)
//   core_reset_o          reset driven into the core
//   core_done_i           done flag from the core
//   busy_o, finished_o, timed_out_o, cycle_count_o   registered status
module core_launcher #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic        ld_sel_i,
    input  logic [8:0]  ld_data_i,
    input  logic        go_i,
    input  logic        clear_i,
    output logic        im_we_o,
    output logic [7:0]  im_addr_o,
    output logic [8:0]  im_wdata_o,
    output logic        dm_we_o,
    output logic [7:0]  dm_addr_o,
    output logic [7:0]  dm_wdata_o,
    output logic        core_reset_o,
    input  logic        core_done_i,
    output logic        busy_o,
    output logic        finished_o,
    output logic        timed_out_o,
    output logic [15:0] cycle_count_o
);

    typedef enum logic [2:0] {StIdle, StRst, StRun, StDone, StTout} state_e;

    localparam logic [8:0]  ImFull  = 9'(IMEM_DEPTH);
    localparam logic [8:0]  DmFull  = 9'(DMEM_DEPTH);
    localparam logic [31:0] RstLast = 32'(RST_CYCLES - 1);
    localparam logic [15:0] MaxLast = 16'(MAX_CYCLES - 1);

    state_e      state_q, state_d;
    logic [8:0]  im_ptr_q, im_ptr_d;
    logic [8:0]  dm_ptr_q, dm_ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic        core_reset_q, busy_q, finished_q, timed_out_q;
    logic        xfer;

    // Load port: ready depends only on state and the selected target's fill level.
    always_comb begin
        ld_ready_o = (state_q == StIdle) && (ld_sel_i ? (dm_ptr_q != DmFull)
                                                      : (im_ptr_q != ImFull));
        // clear (and reset) squash a same-cycle transfer entirely
        xfer       = ld_valid_i & ld_ready_o & ~clear_i & ~reset_i;
        im_we_o    = xfer & ~ld_sel_i;
        im_addr_o  = im_ptr_q[7:0];
        im_wdata_o = ld_data_i;
        dm_we_o    = xfer & ld_sel_i;
        dm_addr_o  = dm_ptr_q[7:0];
        dm_wdata_o = ld_data_i[7:0];
    end

    always_comb begin
        state_d   = state_q;
        im_ptr_d  = im_ptr_q;
        dm_ptr_d  = dm_ptr_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        if (clear_i) begin
            // clear aborts from any state; cycle_count survives until the next go
            state_d  = StIdle;
            im_ptr_d = '0;
            dm_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (im_we_o) im_ptr_d = im_ptr_q + 9'd1;
                    if (dm_we_o) dm_ptr_d = dm_ptr_q + 9'd1;
                    if (go_i) begin
                        state_d   = StRst;
                        rst_cnt_d = '0;
                        cnt_d     = '0;
                    end
                end
                StRst: begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                    if (rst_cnt_q == RstLast) state_d = StRun;
                end
                StRun: begin
                    // done wins over timeout and freezes the count on the done cycle
                    if (core_done_i) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == MaxLast) state_d = StTout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            im_ptr_q     <= '0;
            dm_ptr_q     <= '0;
            cnt_q        <= '0;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            im_ptr_q     <= im_ptr_d;
            dm_ptr_q     <= dm_ptr_d;
            cnt_q        <= cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            // status flags are registered from the next state so they track state_q
            core_reset_q <= (state_d != StRun);
            busy_q       <= (state_d == StRst) || (state_d == StRun);
            finished_q   <= (state_d == StDone);
            timed_out_q  <= (state_d == StTout);
        end
    end

    assign core_reset_o  = core_reset_q;
    assign busy_o        = busy_q;
    assign finished_o    = finished_q;
    assign timed_out_o   = timed_out_q;
    assign cycle_count_o = cnt_q;

endmodule

// File: doc/core_launcher.md
Name: core_launcher

Overview:
- Sits directly upstream of the processor top level. Owns its `reset` and preloads both memories.
- Streams 9-bit instruction words into instruction memory and 8-bit bytes into data memory through a valid/ready load port.
- On `go`, holds core reset for a fixed number of cycles, then releases it.
- Counts execution cycles until the core raises `done`, or aborts on timeout and re-asserts core reset.

Parameters:
- IMEM_DEPTH, 256, number of instruction-memory words loadable (1..256).
- DMEM_DEPTH, 256, number of data-memory bytes loadable (1..256).
- RST_CYCLES, 2, cycles `core_reset` is held after `go` (>=1).
- MAX_CYCLES, 65535, run-cycle limit before timeout (<= 2^16-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  launcher can accept load word.
- ld_sel  in  1  0 = instruction memory, 1 = data memory.
- ld_data  in  9  load payload; bits [7:0] only used when ld_sel=1.
- go  in  1  single-cycle start request.
- clear  in  1  single-cycle return-to-idle / pointer rewind.
- im_we  out  1  instruction memory write enable.
- im_addr  out  8  instruction memory write address.
- im_wdata  out  9  instruction word.
- dm_we  out  1  data memory write enable.
- dm_addr  out  8  data memory write address.
- dm_wdata  out  8  data byte.
- core_reset  out  1  reset to the core (drives its `reset`).
- core_done  in  1  `done` from the core.
- busy  out  1  high in S_RST and S_RUN.
- finished  out  1  high in S_DONE.
- timed_out  out  1  high in S_TOUT.
- cycle_count  out  16  run cycles counted.

Behaviour:
- Reset (synchronous, active-high):
  - state = S_IDLE.
  - im_ptr = dm_ptr = 0; cycle_count = 0; rst_cnt = 0.
  - core_reset = 1; busy = finished = timed_out = 0.
  - im_we = dm_we = 0.
  - Reset mid-run aborts immediately; the next cycle is S_IDLE with core_reset = 1.
- States: S_IDLE, S_RST, S_RUN, S_DONE, S_TOUT. core_reset is 1 in every state except S_RUN.
- S_IDLE load path:
  - ld_ready = 1 unless the selected target is full (im_ptr==IMEM_DEPTH for sel=0, dm_ptr==DMEM_DEPTH for sel=1).
  - ld_ready is combinational on ld_sel and must not depend on ld_valid.
  - Transfer happens when ld_valid & ld_ready.
  - Instruction write (sel=0): im_we = 1 in the same cycle (zero latency); im_addr = im_ptr; im_wdata = ld_data; im_ptr increments next edge.
  - Data write (sel=1): same rule using dm_* and ld_data[7:0].
  - Pointers are 9 bits internally; addresses are the low 8 bits.
  - Pointers saturate at DEPTH with no wrap; further words of that type stall (ld_ready=0). Words of the other type still flow.
  - clear in S_IDLE zeroes both pointers. clear has priority over a same-cycle transfer: that transfer is not counted and the write is suppressed.
- go in S_IDLE:
  - Next state S_RST; rst_cnt = 0; cycle_count = 0.
  - A transfer in the same cycle as go still completes.
  - go outside S_IDLE is ignored.
- S_RST:
  - ld_ready = 0; core_reset = 1; rst_cnt increments.
  - Leaves for S_RUN after exactly RST_CYCLES cycles in S_RST.
- S_RUN:
  - core_reset = 0; ld_ready = 0.
  - If core_done = 1: go to S_DONE; cycle_count not incremented that cycle.
  - Else if cycle_count == MAX_CYCLES-1: increment, then go to S_TOUT.
  - Else: increment.
  - Consequence: if done is high in the first S_RUN cycle, cycle_count = 0.
  - Priority: core_done over timeout in the same cycle.
- S_DONE and S_TOUT:
  - cycle_count frozen; core_reset = 1.
  - Status flags held until clear.
  - clear returns to S_IDLE, zeroes pointers, keeps cycle_count until the next go.
- clear in S_RST or S_RUN aborts to S_IDLE (core_reset = 1 next cycle, pointers zeroed).
- All outputs except ld_ready, im_we/addr/wdata and dm_we/addr/wdata are registered.

Test Plan:
- Load 3 instruction words 0x1A3, 0x005, 0x0E0, then 2 data bytes 0x7F, 0x80, with ld_valid held high -> im_we pulses at addr 0,1,2 with those words; dm_we at addr 0,1 with 0x7F, 0x80; ld_ready stays 1.
- go with RST_CYCLES=2 -> core_reset high exactly 2 cycles after go, then low; busy=1 throughout; core_done raised on the 10th S_RUN cycle -> finished=1, cycle_count=9, core_reset=1.
- MAX_CYCLES=20, core_done never asserted -> timed_out=1 after 20 S_RUN cycles, cycle_count=20, core_reset re-asserted; a later go is ignored until clear.
- IMEM_DEPTH=4: push 6 instruction words, with a data byte interleaved after the 5th -> only 4 imem writes (addr 0..3); ld_ready=0 for sel=0; the data byte is still written at dm addr 0.
- Assert reset in the 5th S_RUN cycle -> next cycle state S_IDLE, core_reset=1, cycle_count=0, pointers 0. Separately, clear coincident with a transfer -> no write, pointers 0.
- core_done high in the first S_RUN cycle -> finished=1, cycle_count=0.
